// File: rtl/tff_count_sequencer_pkg.sv
// Shared opcodes and FSM state encoding for the toggle-flop count sequencer.
package tff_count_sequencer_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_LOAD = 2'b11
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: q flips on every clock edge where t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Toggle storage with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Command sequencer that drives per-bit toggle enables into a bank of toggle flops so the bank
// behaves as a counter (up/down N steps) or a loadable register.
module tff_count_sequencer
  import tff_count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] load_val_q;
  logic             hold_q;
  logic             done_q;
  logic             wrap_q;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             up_run;
  logic             dn_run;
  logic             step_en;
  logic             wrap_event;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;

  // A counting step happens only in UP/DOWN with steps left and no abort pending.
  assign step_en = ((state_q == S_UP) || (state_q == S_DOWN)) && !abort && (remaining_q != '0);

  assign wrap_event = step_en && (((state_q == S_UP) && (&q)) || ((state_q == S_DOWN) && ~(|q)));

  // Ripple-style toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t   = '0;
    dn_t   = '0;
    up_run = 1'b1;
    dn_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_run;
      dn_t[i] = dn_run;
      up_run  = up_run & q[i];
      dn_run  = dn_run & ~q[i];
    end
  end

  // Select the toggle vector applied to the bank this cycle.
  always_comb begin
    t = '0;
    unique case (state_q)
      S_UP:    if (step_en) t = up_t;
      S_DOWN:  if (step_en) t = dn_t;
      S_LOAD:  if (!hold_q) t = q ^ load_val_q;
      default: t = '0;
    endcase
  end

  // FSM, step counter and registered done/wrap pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      load_val_q  <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= wrap_event;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining_q <= cmd_data;
            load_val_q  <= cmd_data;
            hold_q      <= (cmd_op == OP_HOLD);
            unique case (cmd_op)
              OP_UP:   state_q <= S_UP;
              OP_DOWN: state_q <= S_DOWN;
              default: state_q <= S_LOAD;
            endcase
          end
        end
        S_UP, S_DOWN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (remaining_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            remaining_q <= remaining_q - WIDTH'(1);
            if (remaining_q == WIDTH'(1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed self-checking bench for tff_count_sequencer (WIDTH = 4).
module tb_tff_count_sequencer;
  import tff_count_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       wrap;

  int total;
  int passed;

  tff_count_sequencer #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic [3:0] eq, input logic eb, input logic ed,
                        input logic ew);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_data  = 4'h7;
    abort     = 1'b0;

    // Reset held for two cycles with a command pending: it must be ignored.
    tick();
    tick();
    status("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    rst       = 1'b1;
    tick();
    status("idle", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("idle.ready", 32'(cmd_ready), 32'd1);

    // Up 5 from 0.
    issue(OP_UP, 4'd5);
    chk("up.accept_busy", 32'(busy), 32'd1);
    chk("up.accept_ready", 32'(cmd_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      status("up.step", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    status("up.last", 4'h5, 1'b0, 1'b1, 1'b0);
    tick();
    chk("up.done_clear", 32'(done), 32'd0);

    // Load 1, then down 3 wrapping through zero.
    issue(OP_LOAD, 4'h1);
    tick();
    status("ld1", 4'h1, 1'b0, 1'b1, 1'b0);
    issue(OP_DOWN, 4'd3);
    tick();
    status("dn.e1", 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    status("dn.e2", 4'hF, 1'b1, 1'b0, 1'b1);
    tick();
    status("dn.e3", 4'hE, 1'b0, 1'b1, 1'b0);

    // Load A with UP 6 held valid behind it.
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 4'hA;
    tick();
    cmd_op    = OP_UP;
    cmd_data  = 4'd6;
    tick();
    status("ldA", 4'hA, 1'b0, 1'b1, 1'b0);
    chk("ldA.ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 4'h3;
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.q", 32'(q), 32'hA);
    tick();
    chk("b2b.B", 32'(q), 32'hB);
    tick();
    chk("b2b.C", 32'(q), 32'hC);
    tick();
    chk("b2b.D", 32'(q), 32'hD);
    tick();
    chk("b2b.E", 32'(q), 32'hE);
    tick();
    status("b2b.F", 4'hF, 1'b1, 1'b0, 1'b0);
    tick();
    status("b2b.wrap", 4'h0, 1'b0, 1'b1, 1'b1);

    // Up 10 aborted once q reaches 3.
    issue(OP_UP, 4'd10);
    tick();
    tick();
    tick();
    chk("ab.pre", 32'(q), 32'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    status("ab.stop", 4'h3, 1'b0, 1'b0, 1'b0);
    chk("ab.ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("ab.no_done", 32'(done), 32'd0);

    // Down with zero steps.
    issue(OP_DOWN, 4'd0);
    tick();
    status("dn0", 4'h3, 1'b0, 1'b1, 1'b0);

    // Hold ignores data; abort during LOAD-like state is ignored.
    issue(OP_HOLD, 4'h9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    status("hold", 4'h3, 1'b0, 1'b1, 1'b0);

    // Up 8 with asynchronous reset after four steps.
    issue(OP_UP, 4'd8);
    for (int i = 0; i < 4; i++) tick();
    chk("rr.pre", 32'(q), 32'h7);
    #2;
    rst = 1'b0;
    #1;
    status("rr.async", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rr.ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rr.no_done", 32'(done), 32'd0);
    issue(OP_UP, 4'd2);
    tick();
    tick();
    status("rr.after", 4'h2, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller that sequences a WIDTH-bit bank of toggle flip-flops so the bank acts as a commanded counter/register.
- Accepts valid/ready commands (hold, count up N steps, count down N steps, load value).
- Drives per-bit toggle enables into the bank and reports completion and wrap events.
- Sits between a host/test sequencer and the toggle-flop register datapath.

Parameters:
WIDTH, 4, bit width of the toggle-flop bank and of cmd_data

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 hold, 01 count up, 10 count down, 11 load
cmd_data  input  WIDTH  step count for up/down; load value for load; ignored for hold
abort  input  1  terminate a running up/down command
q  output  WIDTH  current bank value
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse after a command completes normally
wrap  output  1  one-cycle pulse in the cycle after q wraps (up 1..1->0..0, down 0..0->1..1)

Behaviour:
- Reset (rst=0, asynchronous): q=0, state=IDLE, busy=0, done=0, wrap=0, step counter=0; cmd_ready=1 (IDLE). Commands are ignored while rst=0. Reset asserted mid-command aborts it immediately with no done.
- FSM states: IDLE, UP, DOWN, LOAD.
- Accept: cmd_valid && cmd_ready at edge E0.
  - op 01 -> UP; op 10 -> DOWN; op 11 -> LOAD; op 00 -> LOAD-like single cycle with zero toggles (hold).
  - remaining <= cmd_data and load_val <= cmd_data are captured at E0.
- Toggle vector t[i], applied as q[i] <= q[i] ^ t[i]:
  - UP: t[0]=1, t[i]=&q[i-1:0]
  - DOWN: t[0]=1, t[i]=&~q[i-1:0]
  - LOAD: t = q ^ load_val
  - hold/IDLE: t=0
- Up/down with N>0: q changes at edges E1..EN, one step per cycle, and remaining decrements each step. At EN the state returns to IDLE and done=1 for the cycle after EN. cmd_ready is high after EN, so the next command can be accepted at EN+1 (no bubble beyond that).
- Up/down with N=0: no change to q; IDLE and done=1 after E1.
- Load/hold: q updated (or unchanged) at E1; done=1 after E1.
- wrap is registered and high for exactly the one cycle after the edge where q wrapped. It can coincide with done. Multiple wraps within a command each pulse.
- Abort: sampled only in UP/DOWN. At the next edge there is no toggle, the FSM goes to IDLE, done stays 0, and q holds. Abort is ignored in IDLE and LOAD.
- cmd_valid while busy: not accepted. The host holds valid and data until ready. cmd_data changes during a run have no effect.
- Step counter width is WIDTH. N up to 2^WIDTH-1 steps per command.

Decomposition:
- Shared package/header: opcode constants OP_HOLD=2'b00, OP_UP=2'b01, OP_DOWN=2'b10, OP_LOAD=2'b11; state encodings S_IDLE, S_UP, S_DOWN, S_LOAD.
- Sub-module tff_cell: a single toggle bit (clk, rst active-low async, t, q), instantiated WIDTH times via generate.
- FSM, step counter and toggle-vector logic stay in tff_count_sequencer.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, no command -> q=4'h0, busy=0, done=0, cmd_ready=1.
- Up run: from q=0, op=UP, data=5 -> q steps 1,2,3,4,5 on E1..E5; busy=1 for 5 cycles; done pulses once after E5; wrap=0.
- Down wrap: load 4'h1 (done after E1), then op=DOWN, data=3 -> q=0,F,E; wrap pulses once after E2; done after E3.
- Load plus back-to-back: op=LOAD data=4'hA, then op=UP data=6 held valid -> q=A after E1; UP accepted the next cycle; q=B,C,D,E,F,0; wrap on the F->0 step coinciding with done.
- Abort and zero-step: op=UP data=10 from q=0, abort at 3rd busy cycle -> q stops at 3, done=0, cmd_ready=1. Then op=DOWN data=0 -> q stays 3, done pulses after E1.
- Reset mid-run: op=UP data=8, drop rst asynchronously after 4 steps -> q=0, busy=0 immediately (no clock edge), no done; a new command after release works.
